// File: rtl/mio_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// mio_pkg
// Shared types and constants for the MIO bus responder:
//   mio_state_e - responder FSM states
//   mio_tgt_e   - decoded access target (RAM, LED, SW, CNT, NONE)
//   MIO_*       - base addresses of the mapped regions
//   mio_decode  - byte address -> target; address bits [1:0] are ignored
// -----------------------------------------------------------------------------
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } mio_state_e;

    typedef enum logic [2:0] {
        TGT_RAM  = 3'd0,
        TGT_LED  = 3'd1,
        TGT_SW   = 3'd2,
        TGT_CNT  = 3'd3,
        TGT_NONE = 3'd4
    } mio_tgt_e;

    localparam logic [31:0] MIO_RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] MIO_LED_ADDR = 32'hE000_0000;
    localparam logic [31:0] MIO_SW_ADDR  = 32'hF000_0000;
    localparam logic [31:0] MIO_CNT_ADDR = 32'hF000_0004;

    // The RAM window spans 4 * 2^ram_aw bytes from MIO_RAM_BASE; every
    // address that hits no region decodes to TGT_NONE.
    function automatic mio_tgt_e mio_decode(input logic [31:0] addr,
                                            input int unsigned ram_aw);
        logic [31:0] ram_off;
        ram_off = addr - MIO_RAM_BASE;
        if ((ram_off >> (ram_aw + 2)) == 32'd0)  return TGT_RAM;
        if (addr[31:2] == MIO_LED_ADDR[31:2])    return TGT_LED;
        if (addr[31:2] == MIO_SW_ADDR[31:2])     return TGT_SW;
        if (addr[31:2] == MIO_CNT_ADDR[31:2])    return TGT_CNT;
        return TGT_NONE;
    endfunction

endpackage

// File: rtl/mio_bus_responder_if.sv
// -----------------------------------------------------------------------------
// mio_bus_responder_if
// CPU-side MIO request/response bundle.
//   CPU_MIO   - request valid, held by the CPU until MIO_ready
//   mem_w     - 1 = write, 0 = read
//   addr_bus  - byte address
//   Data_out  - CPU write data
//   Data_in   - read data, meaningful only while MIO_ready = 1
//   MIO_ready - one-cycle completion pulse
// Modports: master (CPU side), slave (responder side).
// -----------------------------------------------------------------------------
interface mio_bus_responder_if;

    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] addr_bus;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;

    modport master (
        output CPU_MIO, mem_w, addr_bus, Data_out,
        input  Data_in, MIO_ready
    );

    modport slave (
        input  CPU_MIO, mem_w, addr_bus, Data_out,
        output Data_in, MIO_ready
    );

endinterface

// File: rtl/mio_bus_responder_counter.sv
// -----------------------------------------------------------------------------
// mio_counter
// 32-bit free-running cycle counter, wraps 0xFFFF_FFFF -> 0.
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears the count
//   load     - replace the count with load_val (visible the next cycle)
//   load_val - value to load
//   count    - current count
// -----------------------------------------------------------------------------
module mio_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mio_bus_responder.sv
// -----------------------------------------------------------------------------
// mio_bus_responder
// MIO-side responder between the CPU core and board RAM/GPIO. A request is
// latched in IDLE, decoded to RAM / LED / switches / cycle counter / nothing,
// and completed with a one-cycle MIO_ready pulse in RESP.
//
// Build option: MIO_WAIT_EN - when defined, RAM accesses spend RAM_WAIT
// extra cycles in WAIT; when undefined, WAIT and its counter are absent.
//
// Parameters: RAM_AW (RAM word-address width), RAM_WAIT (1..15).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - CPU request/response (mio_bus_responder_if.slave)
//   ram_addr   - RAM word address (held from ACCESS until the next request)
//   ram_we     - RAM write strobe, ACCESS cycle only
//   ram_din    - RAM write data
//   ram_dout   - synchronous RAM read data
//   sw         - switch inputs
//   led        - LED register
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for CPU_MIO; request is latched on acceptance
// ACCESS | RAM address driven, writes strobed/committed this cycle
// WAIT   | slow-RAM wait cycles (MIO_WAIT_EN builds only)
// RESP   | MIO_ready pulse, Data_in muxed from the selected source
// -----------------------------------------------------------------------------
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW   = 10,
    parameter int unsigned RAM_WAIT = 2
) (
    input  logic                clk,
    input  logic                rst,
    mio_bus_responder_if.slave  bus,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic                ram_we,
    output logic [31:0]         ram_din,
    input  logic [31:0]         ram_dout,
    input  logic [15:0]         sw,
    output logic [15:0]         led
);

    mio_state_e        state_q, state_d;
    logic [RAM_AW-1:0] word_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    mio_tgt_e          tgt_q;
    logic [15:0]       led_q;
    logic [31:0]       cnt_val;

    logic accept;
    logic wr_access;
    logic cnt_load;

    assign accept    = (state_q == ST_IDLE) && bus.CPU_MIO;
    assign wr_access = (state_q == ST_ACCESS) && we_q;
    assign cnt_load  = wr_access && (tgt_q == TGT_CNT);

    // Request latch and LED register. The request is decoded once at
    // acceptance, so later changes on addr_bus/Data_out are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            tgt_q   <= TGT_NONE;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q  <= bus.addr_bus[RAM_AW+1:2];
                wdata_q <= bus.Data_out;
                we_q    <= bus.mem_w;
                tgt_q   <= mio_decode(bus.addr_bus, RAM_AW);
            end
            if (wr_access && (tgt_q == TGT_LED)) begin
                led_q <= wdata_q[15:0];
            end
        end
    end

`ifdef MIO_WAIT_EN
    localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);

    // Down-counter: loaded in ACCESS, WAIT ends when it reaches zero,
    // giving exactly RAM_WAIT cycles in WAIT.
    logic [3:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            wait_cnt_q <= WAIT_LAST;
        end else if ((state_q == ST_WAIT) && (wait_cnt_q != 4'd0)) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end
`else
    logic [31:0] unused_ram_wait;
    assign unused_ram_wait = RAM_WAIT;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.CPU_MIO) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
`ifdef MIO_WAIT_EN
                state_d = (tgt_q == TGT_RAM) ? ST_WAIT : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef MIO_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response mux is combinational so RAM data arriving on ram_dout in the
    // RESP cycle is forwarded without an extra register stage.
    always_comb begin
        bus.MIO_ready = (state_q == ST_RESP);
        bus.Data_in   = '0;
        if (state_q == ST_RESP) begin
            case (tgt_q)
                TGT_RAM: bus.Data_in = ram_dout;
                TGT_LED: bus.Data_in = {16'h0000, led_q};
                TGT_SW:  bus.Data_in = {16'h0000, sw};
                TGT_CNT: bus.Data_in = cnt_val;
                default: bus.Data_in = '0;
            endcase
        end
    end

    // rst gates the strobe combinationally so a reset landing in ACCESS
    // cannot corrupt RAM.
    assign ram_we   = wr_access && (tgt_q == TGT_RAM) && !rst;
    assign ram_addr = word_q;
    assign ram_din  = wdata_q;
    assign led      = led_q;

    mio_counter u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (wdata_q),
        .count    (cnt_val)
    );

endmodule

// File: tb/tb_mio_bus_responder.sv
`timescale 1ns/1ps
module tb_mio_bus_responder;
    import mio_pkg::*;

    localparam int unsigned AW          = 10;
    localparam int unsigned TB_RAM_WAIT = 3;
`ifdef MIO_WAIT_EN
    localparam int RAM_EXTRA = TB_RAM_WAIT;
`else
    localparam int RAM_EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;
    logic [15:0]   sw = 16'h0000;
    logic [15:0]   led;

    mio_bus_responder_if bus();

    mio_bus_responder #(.RAM_AW(AW), .RAM_WAIT(TB_RAM_WAIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .sw       (sw),
        .led      (led)
    );

    initial forever #5 clk = ~clk;

    // Board RAM: synchronous read, read-before-write.
    logic [31:0] board_ram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) board_ram[i] = '0;
    always @(posedge clk) begin
        if (ram_we) board_ram[ram_addr] <= ram_din;
        ram_dout <= board_ram[ram_addr];
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // ---------------- reference model (architectural view) ----------------
    logic [31:0] ram_m [int];
    logic [15:0] led_m = '0;
    logic [31:0] cnt_base_val = '0;
    int          cnt_base_cyc = 0;
    int          exp_we_total = 0;

    function automatic mio_tgt_e ref_target(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < (32'd4 << AW))   return TGT_RAM;
        if (w == 32'hE000_0000)  return TGT_LED;
        if (w == 32'hF000_0000)  return TGT_SW;
        if (w == 32'hF000_0004)  return TGT_CNT;
        return TGT_NONE;
    endfunction

    function automatic logic [31:0] ref_cnt_at(input int c);
        return cnt_base_val + 32'(c - cnt_base_cyc);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk_data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_issued = 0;
    int n_ready = 0;
    int we_pulses = 0;
    logic [AW-1:0] last_we_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                we_pulses++;
                last_we_addr = ram_addr;
            end
            if (bus.MIO_ready === 1'b1) begin
                n_ready++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("ready_cycle@%h", e.addr), 32'(cyc), 32'(e.cyc));
                    if (e.chk_data) check($sformatf("read_data@%h", e.addr), bus.Data_in, e.data);
                end
            end
        end
    end

    // Must be called #1 after a rising edge with the responder idle.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic scramble);
        exp_t     e;
        mio_tgt_e t;
        int       n;
        bit       got;
        bus.CPU_MIO  = 1'b1;
        bus.mem_w    = we;
        bus.addr_bus = addr;
        bus.Data_out = data;
        n = cyc;
        t = ref_target(addr);
        e.addr     = addr;
        e.cyc      = n + 2 + ((t == TGT_RAM) ? RAM_EXTRA : 0);
        e.chk_data = !we;
        case (t)
            TGT_RAM: e.data = ram_m.exists(int'(addr[AW+1:2])) ? ram_m[int'(addr[AW+1:2])] : 32'h0;
            TGT_LED: e.data = {16'h0, led_m};
            TGT_SW:  e.data = {16'h0, sw};
            TGT_CNT: e.data = ref_cnt_at(e.cyc);
            default: e.data = 32'h0;
        endcase
        if (we) begin
            case (t)
                TGT_RAM: begin ram_m[int'(addr[AW+1:2])] = data; exp_we_total++; end
                TGT_LED: led_m = data[15:0];
                TGT_CNT: begin cnt_base_val = data; cnt_base_cyc = n + 2; end
                default: ;
            endcase
        end
        sb_q.push_back(e);
        n_issued++;
        @(posedge clk); #1;
        if (scramble) begin
            bus.addr_bus = $urandom;
            bus.Data_out = $urandom;
            bus.mem_w    = 1'($urandom_range(0, 1));
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.MIO_ready === 1'b1) got = 1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got no ready for addr %h expected one", addr);
            if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        end else begin
            check("led_at_resp", {16'h0, led}, {16'h0, led_m});
        end
        @(posedge clk); #1;
        bus.CPU_MIO = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.CPU_MIO = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        led_m        = '0;
        cnt_base_val = '0;
        cnt_base_cyc = cyc;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int we_before;
        int sel;
        logic [31:0] a;
        bus.CPU_MIO  = 1'b0;
        bus.mem_w    = 1'b0;
        bus.addr_bus = '0;
        bus.Data_out = '0;

        do_reset();
        @(negedge clk);
        check("rst_ready",    {31'h0, bus.MIO_ready}, 32'h0);
        check("rst_data_in",  bus.Data_in, 32'h0);
        check("rst_ram_we",   {31'h0, ram_we}, 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_din",  ram_din, 32'h0);
        check("rst_led",      {16'h0, led}, 32'h0);
        @(posedge clk); #1;

        issue(1'b0, 32'hE000_0000, 32'h0, 1'b0);

        we_before = we_pulses;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        check("ram_we_pulses", 32'(we_pulses - we_before), 32'd1);
        check("ram_we_addr",   32'(last_we_addr), 32'd4);
        issue(1'b0, 32'h0000_0010, 32'h0, 1'b1);

        issue(1'b1, 32'hE000_0000, 32'h0000_00A5, 1'b0);
        issue(1'b0, 32'hE000_0000, 32'h0, 1'b0);
        sw = 16'h1234;
        issue(1'b0, 32'hF000_0000, 32'h0, 1'b0);
        issue(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 1'b0);

        issue(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1'b0);
        issue(1'b0, 32'hF000_0004, 32'h0, 1'b0);

        issue(1'b1, 32'h0000_0FFC, 32'hCAFE_0001, 1'b0);
        issue(1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 1'b0);
        issue(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        issue(1'b0, 32'h0000_0FFF, 32'h0, 1'b0);
        issue(1'b0, 32'h1000_0000, 32'h0, 1'b0);

        // Reset landing in the ACCESS cycle of a RAM write.
        we_before = we_pulses;
        bus.CPU_MIO  = 1'b1;
        bus.mem_w    = 1'b1;
        bus.addr_bus = 32'h0000_0020;
        bus.Data_out = 32'h5555_AAAA;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.CPU_MIO = 1'b0;
        @(negedge clk);
        check("rst_access_ram_we", {31'h0, ram_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        led_m        = '0;
        cnt_base_val = '0;
        cnt_base_cyc = cyc;
        @(negedge clk);
        check("rst_access_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("rst_access_led",   {16'h0, led}, 32'h0);
        idle_cycles(4);
        check("rst_access_no_we", 32'(we_pulses - we_before), 32'd0);
        issue(1'b0, 32'h0000_0020, 32'h0, 1'b0);
        issue(1'b0, 32'hF000_0004, 32'h0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 200; k++) begin
            sw  = 16'($urandom);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: a = {20'h0, 4'($urandom_range(0, 15)), 6'h0, 2'($urandom)} & 32'h0000_0FFF;
                4:          a = {22'h0, 8'($urandom_range(1016, 1023) - 1016 + 248), 2'($urandom)};
                5:          a = 32'hE000_0000 | 32'(2'($urandom));
                6:          a = 32'hF000_0000 | 32'(2'($urandom));
                7:          a = 32'hF000_0004 | 32'(2'($urandom));
                default:    a = $urandom | 32'h0000_1000;
            endcase
            if (sel <= 3) a = {20'h0, 4'($urandom_range(0, 15)), 8'h0} | 32'(2'($urandom));
            if (sel == 4) a = 32'h0000_0F00 | {24'h0, 6'($urandom), 2'($urandom)};
            issue(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(5);
        check("ready_count",   32'(n_ready), 32'(n_issued));
        check("sb_empty",      32'(sb_q.size()), 32'd0);
        check("ram_we_total",  32'(we_pulses), 32'(exp_we_total));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder on the CPU's MIO side: accepts word requests qualified by `CPU_MIO`/`mem_w`, decodes the address into data RAM, LED register, switch port or cycle counter, and returns read data with a one-cycle `MIO_ready` pulse. It sits between the single-cycle CPU core and the board-level RAM/GPIO. The CPU stalls while `MIO_ready` is low.

## Interface
- `RAM_AW`, 10: RAM word-address width (1024 words).
- `RAM_WAIT`, 2: extra RAM wait cycles, legal range 1..15; used only with `MIO_WAIT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `CPU_MIO` in 1: request valid; held by CPU until `MIO_ready`.
- `mem_w` in 1: 1 = write, 0 = read; sampled with `CPU_MIO`.
- `addr_bus` in 32: byte address; bits [1:0] ignored.
- `Data_out` in 32: CPU write data.
- `Data_in` out 32: read data to CPU, valid only while `MIO_ready`=1.
- `MIO_ready` out 1: one-cycle completion pulse.
- `ram_addr` out RAM_AW: RAM word address.
- `ram_we` out 1: RAM write strobe.
- `ram_din` out 32: RAM write data.
- `ram_dout` in 32: synchronous RAM read data, valid one cycle after `ram_addr`.
- `sw` in 16: switch inputs.
- `led` out 16: LED register.

## Operation
- Address map:
  - 0x0000_0000–(4·2^RAM_AW−4): RAM.
  - 0xE000_0000: LED, R/W, low 16 bits.
  - 0xF000_0000: switches, read-only; write ignored; reads zero-extended.
  - 0xF000_0004: counter, R/W.
  - All other addresses: reads return 0, writes are dropped, and the access still completes.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE: if `CPU_MIO`=1, latch the address, write data and `mem_w`, then go to ACCESS.
  - ACCESS: drive `ram_addr` from the latched address. For a RAM write, `ram_we`=1 for exactly this cycle. LED and counter writes commit at the end of this cycle. Next state is WAIT for RAM accesses with `MIO_WAIT_EN`, otherwise RESP.
  - WAIT: hold `ram_addr` and count `RAM_WAIT` cycles, then go to RESP.
  - RESP: `MIO_ready`=1 and `Data_in` = selected source, muxed combinationally from `ram_dout` or the peripheral value. Always return to IDLE; `CPU_MIO` is not sampled in RESP.
- Counter: 32-bit free-running, +1 every cycle, wraps 0xFFFF_FFFF→0. A counter write loads `Data_out`, and the written value appears on the next cycle. A read returns the value at the start of RESP.
- Reset: state=IDLE, `MIO_ready`=0, `Data_in`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `led`=0, counter=0. Reset asserted in ACCESS suppresses `ram_we` and all peripheral commits; the in-flight request is lost and the CPU must re-issue it.

## Timing
- Request accepted in cycle n (IDLE, `CPU_MIO`=1).
- `MIO_ready` in cycle n+2; for RAM with `MIO_WAIT_EN`, in cycle n+2+`RAM_WAIT`. Non-RAM targets never wait.
- The earliest next acceptance is the cycle after RESP, so back-to-back throughput is one access per 3 cycles.
- Changing `addr_bus`/`Data_out` after acceptance has no effect.

## Configuration
- `MIO_WAIT_EN` defined: RAM accesses insert `RAM_WAIT` WAIT cycles, modelling slow memory.
- `MIO_WAIT_EN` not defined: the WAIT state and its counter are not compiled in, `RAM_WAIT` is unused, and all accesses take 2 cycles.

## Structure
- Package `mio_pkg` holds:
  - State enum.
  - Base-address constants `MIO_RAM_BASE`, `MIO_LED_ADDR`, `MIO_SW_ADDR`, `MIO_CNT_ADDR`.
  - Target-select enum: RAM, LED, SW, CNT, NONE.
- One sub-module `mio_counter` (clk, rst, load, load_val, count[31:0]) holds the free-running counter. Decode and FSM stay in the top module.

## Test plan
- Reset, then read 0xE000_0000 → `MIO_ready` in cycle n+2 with `Data_in`=0; `led`=0.
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → `ram_we` high for one cycle with `ram_addr`=4; the read returns 0xDEADBEEF.
- Write 0x0000_00A5 to LED → `led`=0x00A5 from cycle n+2; read back gives 0x0000_00A5. With `sw`=0x1234, a read of 0xF000_0000 gives 0x0000_1234.
- Write 0xFFFF_FFFE to counter → read after wrap returns a small value (<0x10), confirming wrap to 0.
- Assert `rst` during ACCESS of a RAM write → `ram_we` stays 0, state IDLE next cycle, no `MIO_ready`.
- With `MIO_WAIT_EN`, `RAM_WAIT`=3: RAM read → `MIO_ready` at n+5. LED read still at n+2. An unmapped read of 0x1000_0000 → `Data_in`=0 at n+2.
